obus_mem_responder: RTL

OBUS_MEM_RESPONDER -- requirements
Module: obus_mem_responder

---
 rtl/obus_mem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/obus_mem_responder.sv
// Memory responder on the OBUS: queues read requests addressed to BUS_ID,
// fetches each line from the backing store and returns it on the response bus.
module obus_mem_responder #(
   parameter logic [5:0]  BUS_ID = 6'd0,
   parameter int unsigned SIG_W  = 8,
   parameter int unsigned RSP_W  = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SIG_W-1:0]   reqIn_signals,
   input  logic [9:0]         reqIn_src_req,
   input  logic [9:0]         reqIn_dst_req,
   input  logic [36:0]        reqIn_address,
   input  logic               reqIn_en,
   output logic               reqIn_doStall,
   output logic               mem_req,
   output logic [36:0]        mem_addr,
   input  logic               mem_ack,
   input  logic [511:0]       mem_rdata,
   output logic [RSP_W-1:0]   rspOut_signals,
   output logic [9:0]         rspOut_src_req,
   output logic [9:0]         rspOut_dst_req,
   output logic [7:0]         rspOut_dataPTR,
   output logic [511:0]       rspOut_data,
   output logic               rspOut_en,
   input  logic               rspOut_stall
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned ID_W   = 10;
   localparam int unsigned ADDR_W = 37;
   localparam int unsigned DATA_W = 512;
   localparam int unsigned SEQ_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MEMREQ = 2'd1,
      ST_SEND   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ID_W-1:0]     r_src_mem  [DEPTH];
   logic [ID_W-1:0]     r_dst_mem  [DEPTH];
   logic [ADDR_W-1:0]   r_addr_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [DATA_W-1:0]   r_data;
   logic [SEQ_W-1:0]    r_seq;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_capture;
   logic [ID_W-1:0]     w_head_src;
   logic [ID_W-1:0]     w_head_dst;
   logic [ADDR_W-1:0]   w_head_addr;
   logic                w_unused;

   // Only bit 0 of the request signals carries meaning for this responder.
   assign w_unused = ^reqIn_signals;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = reqIn_en && (reqIn_dst_req[9:4] == BUS_ID) &&
                        reqIn_signals[0] && !w_full;
   assign w_head_src  = r_src_mem[r_rd_ptr];
   assign w_head_dst  = r_dst_mem[r_rd_ptr];
   assign w_head_addr = r_addr_mem[r_rd_ptr];

   assign reqIn_doStall = w_full && rst;

   // Request FIFO pointers and occupancy; a push while full never happens,
   // even when a pop frees a slot in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset needed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_src_mem[r_wr_ptr]  <= reqIn_src_req;
         r_dst_mem[r_wr_ptr]  <= reqIn_dst_req;
         r_addr_mem[r_wr_ptr] <= reqIn_address;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_seq   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) r_data <= mem_rdata;
         if (w_pop)     r_seq  <= r_seq + SEQ_W'(1);
      end
   end

   // Next-state and bus outputs; everything is forced low while in reset.
   always_comb begin
      w_state_nxt    = r_state;
      w_pop          = 1'b0;
      w_capture      = 1'b0;
      mem_req        = 1'b0;
      mem_addr       = '0;
      rspOut_signals = '0;
      rspOut_src_req = '0;
      rspOut_dst_req = '0;
      rspOut_dataPTR = '0;
      rspOut_data    = '0;
      rspOut_en      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (!w_empty) w_state_nxt = ST_MEMREQ;
         end
         ST_MEMREQ: begin
            mem_req  = 1'b1;
            mem_addr = w_head_addr;
            if (mem_ack) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            rspOut_en      = 1'b1;
            rspOut_signals = RSP_W'(1);
            rspOut_src_req = w_head_dst;
            rspOut_dst_req = w_head_src;
            rspOut_dataPTR = r_seq;
            rspOut_data    = r_data;
            if (!rspOut_stall) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (!rst) begin
         w_pop          = 1'b0;
         w_capture      = 1'b0;
         mem_req        = 1'b0;
         mem_addr       = '0;
         rspOut_signals = '0;
         rspOut_src_req = '0;
         rspOut_dst_req = '0;
         rspOut_dataPTR = '0;
         rspOut_data    = '0;
         rspOut_en      = 1'b0;
      end
   end

endmodule
